// File: rtl/mk14_display_pkg.sv
// Shared definitions for the MK14 display scanner: segment bit positions,
// scan phase encoding and an index-width helper.
package mk14_display_pkg;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   typedef enum logic [0:0] {
      ST_BLANK = 1'b0,
      ST_ON    = 1'b1
   } scan_state_t;

   // Width of a digit index; a single-digit display still needs one bit.
   function automatic int idx_width(input int digits);
      return (digits > 1) ? $clog2(digits) : 1;
   endfunction

endpackage

// File: rtl/mk14_scan_timer.sv
// Slot prescaler for the display scanner. A down-counter times each digit
// slot; the phase register tracks BLANK/ON and the digit index advances at
// the end of every slot.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_BLANK | first BLANK_CYCLES of a slot, every digit driven off
//   ST_ON    | remainder of the slot, current digit may be lit
module mk14_scan_timer
   import mk14_display_pkg::*;
#(
   parameter int SLOT         = 20,
   parameter int BLANK_CYCLES = 4,
   parameter int DIGITS       = 8,
   parameter int IDX_W        = idx_width(DIGITS)
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             slot_start,
   output logic             in_blank,
   output logic [IDX_W-1:0] idx
);

   localparam int CNT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
   // Counter runs SLOT-1 down to 0, so elapsed slot time is CNT_TOP - cnt.
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(SLOT - 1);
   // Count value on the last blank cycle; the next cycle starts ON.
   localparam logic [CNT_W-1:0] CNT_ON  = CNT_W'(SLOT - BLANK_CYCLES);
   localparam scan_state_t      ST_FIRST = (BLANK_CYCLES > 0) ? ST_BLANK : ST_ON;

   logic [CNT_W-1:0] cnt;
   scan_state_t      state;
   logic [IDX_W-1:0] idx_q;

   // Slot down-counter, phase tracking and digit index advance.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt   <= CNT_TOP;
         state <= ST_FIRST;
         idx_q <= '0;
      end else if (cnt == '0) begin
         cnt   <= CNT_TOP;
         state <= ST_FIRST;
         idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
         cnt <= cnt - 1'b1;
         if ((BLANK_CYCLES > 0) && (cnt == CNT_ON)) begin
            state <= ST_ON;
         end
      end
   end

   assign slot_start = (cnt == CNT_TOP);
   assign in_blank   = (state == ST_BLANK);
   assign idx        = idx_q;

endmodule

// File: rtl/mk14_display_scan.sv
// Multiplexed seven-segment scanner for the MK14 eight-digit display.
// Takes a per-frame snapshot of the display bus so CPU writes never tear,
// then walks the digits with a blanking gap before each one.
// Optional dimming: define MK14_DISPLAY_DIM_EN to add a 4-bit brightness
// input that gates the lit phase with a free-running PWM counter.
module mk14_display_scan
   import mk14_display_pkg::*;
#(
   parameter int CLOCK_FREQ_MHZ = 12,
   parameter int DIGITS         = 8,
   parameter int DIGIT_US       = 1000,
   parameter int BLANK_CYCLES   = 16,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit DIG_ACTIVE_LOW = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DIGITS*8-1:0]   display,
`ifdef MK14_DISPLAY_DIM_EN
   input  logic [3:0]            brightness,
`endif
   output logic [7:0]            seg,
   output logic [DIGITS-1:0]     dig,
   output logic                  frame_strobe
);

   localparam int SLOT  = CLOCK_FREQ_MHZ * DIGIT_US;
   localparam int IDX_W = idx_width(DIGITS);

   localparam logic [7:0]        SEG_OFF = {8{SEG_ACTIVE_LOW}};
   localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACTIVE_LOW}};

   if (SLOT <= BLANK_CYCLES + 1) begin : g_bad_slot
      $error("mk14_display_scan: slot of %0d cycles too short for %0d blank cycles",
             SLOT, BLANK_CYCLES);
   end
   if ((DIGITS < 1) || (DIGITS > 8)) begin : g_bad_digits
      $error("mk14_display_scan: DIGITS=%0d outside 1..8", DIGITS);
   end

   logic              slot_start;
   logic              in_blank;
   logic [IDX_W-1:0]  idx;
   logic              frame_edge;
   logic [DIGITS*8-1:0] snap;
   logic [7:0]        cur_byte;
   logic [DIGITS-1:0] dig_onehot;
   logic              lit;

   mk14_scan_timer #(
      .SLOT         (SLOT),
      .BLANK_CYCLES (BLANK_CYCLES),
      .DIGITS       (DIGITS),
      .IDX_W        (IDX_W)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .slot_start (slot_start),
      .in_blank   (in_blank),
      .idx        (idx)
   );

   assign frame_edge = slot_start && (idx == '0);
   assign dig_onehot = DIGITS'(1) << idx;

   // Byte for the current digit; on the snapshot edge the frame register is
   // still being loaded, so digit 0 comes straight from the incoming bus.
   always_comb begin
      cur_byte = snap[int'(idx)*8 +: 8];
      if (frame_edge) begin
         cur_byte = display[7:0];
      end
   end

`ifdef MK14_DISPLAY_DIM_EN
   logic [3:0] pwm;
   logic [3:0] bright_q;

   // Free-running PWM counter and per-frame brightness latch.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pwm      <= '0;
         bright_q <= '0;
      end else begin
         pwm <= pwm + 1'b1;
         if (frame_edge) begin
            bright_q <= brightness;
         end
      end
   end

   assign lit = !in_blank && (pwm <= bright_q);
`else
   assign lit = !in_blank;
`endif

   // Snapshot register and registered pin drivers; seg only moves while
   // every digit is dark.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         snap         <= '0;
         seg          <= SEG_OFF;
         dig          <= DIG_OFF;
         frame_strobe <= 1'b0;
      end else begin
         frame_strobe <= frame_edge;
         if (frame_edge) begin
            snap <= display;
         end
         if (in_blank || slot_start) begin
            seg <= SEG_ACTIVE_LOW ? ~cur_byte : cur_byte;
         end
         if (lit) begin
            dig <= DIG_ACTIVE_LOW ? ~dig_onehot : dig_onehot;
         end else begin
            dig <= DIG_OFF;
         end
      end
   end

endmodule
